// File: rtl/icache_refill_unit_pkg.sv
// Shared geometry, state encoding and address helpers for the ICache refill engine.
package icache_refill_unit_pkg;

  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned CACHE_BLK_SIZE    = 128;
  localparam int unsigned CACHE_TAG_LEN     = 22;
  localparam int unsigned CACHE_GRP_NUM_LEN = 6;
  localparam int unsigned BUS_WIDTH         = 32;
  localparam int unsigned BEATS             = CACHE_BLK_SIZE / BUS_WIDTH;
  localparam int unsigned OFS               = ADDR_W - CACHE_TAG_LEN - CACHE_GRP_NUM_LEN;
  localparam int unsigned BEAT_CNT_W        = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } refill_state_e;

  // Block-granular part of a fetch address; the byte offset is never stored.
  typedef struct packed {
    logic [CACHE_TAG_LEN-1:0]     tag;
    logic [CACHE_GRP_NUM_LEN-1:0] blk_num;
  } line_addr_t;

  function automatic line_addr_t to_line_addr(input logic [ADDR_W-1:0] addr);
    return line_addr_t'(addr[ADDR_W-1:OFS]);
  endfunction

  function automatic logic [ADDR_W-1:0] block_base(input line_addr_t la);
    return {la, OFS'(0)};
  endfunction

endpackage

// File: rtl/icache_refill_buffer.sv
// Beat counter plus line register: each accepted beat lands in the slot selected
// by the counter, beat 0 in the lowest-addressed word.
module icache_refill_buffer
  import icache_refill_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      beat_valid,
  input  logic [BUS_WIDTH-1:0]      beat_data,
  output logic [CACHE_BLK_SIZE-1:0] line,
  output logic                      last_beat
);

  logic [BEAT_CNT_W-1:0]             cnt_q;
  logic [BEATS-1:0][BUS_WIDTH-1:0]   line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (beat_valid) begin
      line_q[cnt_q] <= beat_data;
      cnt_q         <= cnt_q + BEAT_CNT_W'(1);
    end
  end

  assign line      = line_q;
  assign last_beat = (cnt_q == BEAT_CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_refill_unit.sv
// ICache miss refill engine: requests one aligned block, collects its beats and
// writes the assembled line into the set storage one cycle before signalling done.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
(
  input  logic                         cpu_clk,
  input  logic                         cpu_rst,
  input  logic                         miss_req,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         refill_busy,
  output logic                         refill_done,
  output logic                         refill_err,
  output logic [CACHE_BLK_SIZE-1:0]    refill_data,
  output logic                         cache_we,
  output logic [CACHE_TAG_LEN-1:0]     cache_tag,
  output logic [CACHE_GRP_NUM_LEN-1:0] cache_blk_num,
  output logic [CACHE_BLK_SIZE-1:0]    cache_data_w,
  output logic                         mem_rreq,
  output logic [ADDR_W-1:0]            mem_raddr,
  input  logic                         mem_rgnt,
  input  logic                         mem_rvalid,
  input  logic [BUS_WIDTH-1:0]         mem_rdata,
  input  logic                         mem_rlast
);

  refill_state_e state_q, state_d;
  line_addr_t    addr_q;
  logic          err_q;
  logic          accept_c;
  logic          beat_c;
  logic          abort_c;
  logic          last_beat;
  logic [CACHE_BLK_SIZE-1:0] line;

  // Byte offset of the faulting address is irrelevant to a block refill.
  logic unused_ofs;
  assign unused_ofs = ^miss_addr[OFS-1:0];

  assign accept_c = (state_q == ST_IDLE) && miss_req;
  assign beat_c   = (state_q == ST_RECV) && mem_rvalid;
  assign abort_c  = beat_c && mem_rlast && !last_beat;

  // State register
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (miss_req) state_d = ST_REQ;
      ST_REQ:   if (mem_rgnt) state_d = ST_RECV;
      ST_RECV: begin
        if (beat_c) begin
          if (last_beat)      state_d = ST_WRITE;
          else if (mem_rlast) state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address latch and abort pulse
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort_c;
      if (accept_c) begin
        addr_q <= to_line_addr(miss_addr);
      end
    end
  end

  icache_refill_buffer u_buffer (
    .clk        (cpu_clk),
    .rst        (cpu_rst),
    .clear      (accept_c),
    .beat_valid (beat_c),
    .beat_data  (mem_rdata),
    .line       (line),
    .last_beat  (last_beat)
  );

  // Control outputs decode the state register only, so reset drops them at once.
  assign refill_busy   = (state_q != ST_IDLE);
  assign mem_rreq      = (state_q == ST_REQ);
  assign cache_we      = (state_q == ST_WRITE);
  assign refill_done   = (state_q == ST_DONE);
  assign refill_err    = err_q;
  assign mem_raddr     = block_base(addr_q);
  assign cache_tag     = addr_q.tag;
  assign cache_blk_num = addr_q.blk_num;
  assign cache_data_w  = line;
  assign refill_data   = line;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: cycle-exact refill, stall, abort,
// busy-ignore, reset and back-to-back scenarios with hand-computed expectations.
module tb_icache_refill_unit;

  logic         cpu_clk = 1'b0;
  logic         cpu_rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         refill_busy;
  logic         refill_done;
  logic         refill_err;
  logic [127:0] refill_data;
  logic         cache_we;
  logic [21:0]  cache_tag;
  logic [5:0]   cache_blk_num;
  logic [127:0] cache_data_w;
  logic         mem_rreq;
  logic [31:0]  mem_raddr;
  logic         mem_rgnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         mem_rlast;

  int n_checks = 0;
  int n_pass   = 0;
  int rreq_cycles;

  always #5 cpu_clk = ~cpu_clk;

  icache_refill_unit dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .miss_req      (miss_req),
    .miss_addr     (miss_addr),
    .refill_busy   (refill_busy),
    .refill_done   (refill_done),
    .refill_err    (refill_err),
    .refill_data   (refill_data),
    .cache_we      (cache_we),
    .cache_tag     (cache_tag),
    .cache_blk_num (cache_blk_num),
    .cache_data_w  (cache_data_w),
    .mem_rreq      (mem_rreq),
    .mem_raddr     (mem_raddr),
    .mem_rgnt      (mem_rgnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_rlast     (mem_rlast)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    mem_rlast  = last;
    step();
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic grant();
    mem_rgnt = 1'b1;
    step();
    mem_rgnt = 1'b0;
  endtask

  initial begin
    cpu_rst = 1'b1; miss_req = 1'b0; miss_addr = '0;
    mem_rgnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    step(); step();
    chk("rst_busy", refill_busy, 0);
    chk("rst_rreq", mem_rreq, 0);
    chk("rst_we", cache_we, 0);
    chk("rst_done", refill_done, 0);
    chk("rst_err", refill_err, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_data", refill_data, 0);
    cpu_rst = 1'b0;

    // Basic refill, minimum latency
    miss_req = 1'b1; miss_addr = 32'h1C00_0134;
    step();                                   // c1
    miss_req = 1'b0;
    chk("basic_busy", refill_busy, 1);
    chk("basic_rreq", mem_rreq, 1);
    chk("basic_raddr", mem_raddr, 32'h1C00_0130);
    grant();                                  // c2
    chk("basic_rreq_drop", mem_rreq, 0);
    beat(32'h1111_1111, 1'b0);
    beat(32'h2222_2222, 1'b0);
    beat(32'h3333_3333, 1'b0);
    beat(32'h4444_4444, 1'b1);                // c6
    chk("basic_we", cache_we, 1);
    chk("basic_tag", cache_tag, 22'h07_0000);
    chk("basic_blk", cache_blk_num, 6'h13);
    chk("basic_line", cache_data_w, 128'h44444444_33333333_22222222_11111111);
    chk("basic_done_early", refill_done, 0);
    step();                                   // c7
    chk("basic_we_once", cache_we, 0);
    chk("basic_done", refill_done, 1);
    chk("basic_rdata", refill_data, 128'h44444444_33333333_22222222_11111111);
    chk("basic_wdata_hold", cache_data_w, 128'h44444444_33333333_22222222_11111111);
    step();                                   // c8
    chk("basic_idle", refill_busy, 0);
    chk("basic_done_pulse", refill_done, 0);

    // Stalled bus: grant in fifth request cycle, gaps between beats
    miss_req = 1'b1; miss_addr = 32'h0000_1008;
    step();
    miss_req = 1'b0;
    rreq_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_rreq) rreq_cycles++;
      mem_rgnt = (i == 4);
      step();
    end
    mem_rgnt = 1'b0;
    chk("stall_rreq_cycles", rreq_cycles, 5);
    chk("stall_raddr", mem_raddr, 32'h0000_1000);
    beat(32'h1111_1111, 1'b0); step();
    chk("stall_gap_we", cache_we, 0);
    beat(32'h2222_2222, 1'b0); step();
    beat(32'h3333_3333, 1'b0); step();
    chk("stall_gap_busy", refill_busy, 1);
    beat(32'h4444_4444, 1'b0);
    chk("stall_we", cache_we, 1);
    chk("stall_line", cache_data_w, 128'h44444444_33333333_22222222_11111111);
    chk("stall_tag", cache_tag, 22'h00_0004);
    chk("stall_blk", cache_blk_num, 6'h00);
    step();
    chk("stall_done", refill_done, 1);

    // Early rlast aborts; a new miss is taken in the error cycle
    step();
    miss_req = 1'b1; miss_addr = 32'h2000_0010;
    step();
    miss_req = 1'b0;
    grant();
    beat(32'hAAAA_0000, 1'b0);
    beat(32'hAAAA_0001, 1'b1);
    chk("abort_err", refill_err, 1);
    chk("abort_busy", refill_busy, 0);
    chk("abort_we", cache_we, 0);
    miss_req = 1'b1; miss_addr = 32'h2000_0010;
    step();
    chk("abort_err_pulse", refill_err, 0);
    chk("abort_rearm_rreq", mem_rreq, 1);
    chk("abort_rearm_raddr", mem_raddr, 32'h2000_0010);

    // Second miss during refill is ignored
    miss_addr = 32'h0000_0040;
    grant();
    beat(32'hA000_0000, 1'b0);
    beat(32'hA000_0001, 1'b0);
    miss_req = 1'b0;
    beat(32'hA000_0002, 1'b0);
    beat(32'hA000_0003, 1'b0);
    chk("ignore_we", cache_we, 1);
    chk("ignore_tag", cache_tag, 22'h08_0000);
    chk("ignore_blk", cache_blk_num, 6'h01);
    chk("ignore_line", cache_data_w, 128'hA0000003_A0000002_A0000001_A0000000);
    step();
    chk("ignore_done", refill_done, 1);
    step();
    chk("ignore_idle", refill_busy, 0);

    // Reset during RECV after two beats
    miss_req = 1'b1; miss_addr = 32'h3000_0020;
    step();
    miss_req = 1'b0;
    grant();
    beat(32'hDEAD_0000, 1'b0);
    beat(32'hDEAD_0001, 1'b0);
    chk("rstmid_busy_before", refill_busy, 1);
    cpu_rst = 1'b1;
    #1;
    chk("rstmid_busy", refill_busy, 0);
    chk("rstmid_rreq", mem_rreq, 0);
    chk("rstmid_we", cache_we, 0);
    chk("rstmid_wdata", cache_data_w, 0);
    chk("rstmid_raddr", mem_raddr, 0);
    step();
    cpu_rst = 1'b0;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    grant();
    beat(32'hC000_0000, 1'b0);
    beat(32'hC000_0001, 1'b0);
    beat(32'hC000_0002, 1'b0);
    beat(32'hC000_0003, 1'b0);
    chk("rstmid_we_after", cache_we, 1);
    chk("rstmid_tag", cache_tag, 22'h0C_0000);
    chk("rstmid_blk", cache_blk_num, 6'h02);
    chk("rstmid_line", cache_data_w, 128'hC0000003_C0000002_C0000001_C0000000);
    step();
    chk("rstmid_done", refill_done, 1);
    step();

    // Back-to-back misses with miss_req held high
    miss_req = 1'b1; miss_addr = 32'h0000_0150;
    step();                                   // c1
    miss_addr = 32'h0000_0260;
    grant();
    beat(32'h5555_0000, 1'b0);
    beat(32'h5555_0001, 1'b0);
    beat(32'h5555_0002, 1'b0);
    beat(32'h5555_0003, 1'b0);                // c6
    chk("b2b_blk0", cache_blk_num, 6'h15);
    chk("b2b_line0", cache_data_w, 128'h55550003_55550002_55550001_55550000);
    step();                                   // c7
    chk("b2b_done0", refill_done, 1);
    step();                                   // c8
    chk("b2b_idle_c8", refill_busy, 0);
    step();                                   // c9
    miss_req = 1'b0;
    chk("b2b_rreq1", mem_rreq, 1);
    chk("b2b_raddr1", mem_raddr, 32'h0000_0260);
    grant();
    beat(32'h6666_0000, 1'b0);
    beat(32'h6666_0001, 1'b0);
    beat(32'h6666_0002, 1'b0);
    beat(32'h6666_0003, 1'b0);
    chk("b2b_we1", cache_we, 1);
    chk("b2b_blk1", cache_blk_num, 6'h26);
    chk("b2b_line1", cache_data_w, 128'h66660003_66660002_66660001_66660000);
    step();
    chk("b2b_done1", refill_done, 1);
    step();
    chk("b2b_idle_end", refill_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
